// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and width constants for the alu
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - 16-bit logical shift / rotate by 0-15 with last-bit-out carry
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        amt,
    input  logic              left,
    input  logic              rotate,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;
    logic [DATA_W-1:0] rol;
    logic [DATA_W-1:0] ror;
    logic [4:0]        back_amt;

    // The extra bit catches the last bit shifted out; it is zero when amt == 0.
    assign shl_ext  = {1'b0, data} << amt;
    assign shr_ext  = {data, 1'b0} >> amt;
    assign back_amt = 5'd16 - {1'b0, amt};
    assign rol      = (data << amt) | (data >> back_amt);
    assign ror      = (data >> amt) | (data << back_amt);

    always_comb begin
        result = data;
        carry  = 1'b0;
        if (rotate) begin
            result = left ? rol : ror;
            if (amt != 4'd0) begin
                carry = left ? rol[0] : ror[DATA_W-1];
            end
        end else begin
            result = left ? shl_ext[DATA_W-1:0] : shr_ext[DATA_W:1];
            carry  = left ? shl_ext[DATA_W] : shr_ext[0];
        end
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit ALU with one register stage, status flags and tri-stated result
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic              ar_flag,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              out_en,
    output logic [DATA_W-1:0] out,
    output logic [3:0]        flags
);

    logic [DATA_W-1:0]   res_q;
    logic [3:0]          flags_q;
    logic [DATA_W-1:0]   res_next;
    logic [3:0]          flags_next;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   sh_res;
    logic                sh_c;
    logic [DATA_W-1:0]   r;
    logic                c;
    logic                v;
    logic                listed;

    assign sum  = {1'b0, src1} + {1'b0, src2};
    assign prod = src1 * src2;

    alu_shifter u_shifter (
        .data   (src1),
        .amt    (src2[3:0]),
        .left   (opcode == OP_SHL),
        .rotate (ar_flag),
        .result (sh_res),
        .carry  (sh_c)
    );

    always_comb begin
        r      = '0;
        c      = 1'b0;
        v      = 1'b0;
        listed = 1'b1;
        case (opcode)
            OP_ADD: begin
                r = sum[DATA_W-1:0];
                c = sum[DATA_W];
                v = (src1[DATA_W-1] == src2[DATA_W-1]) && (r[DATA_W-1] != src1[DATA_W-1]);
            end
            OP_SUB: begin
                r = src1 - src2;
                c = src1 < src2;
                v = (src1[DATA_W-1] != src2[DATA_W-1]) && (r[DATA_W-1] != src1[DATA_W-1]);
            end
            OP_MUL: begin
                r = prod[DATA_W-1:0];
                c = |prod[2*DATA_W-1:DATA_W];
                v = c;
            end
            OP_DIV: begin
                if (src2 == '0) begin
                    r = '1;
                    v = 1'b1;
                end else begin
                    r = src1 / src2;
                end
            end
            OP_AND: r = src1 & src2;
            OP_OR:  r = src1 | src2;
            OP_XOR: r = src1 ^ src2;
            OP_SHL, OP_SHR: begin
                r = sh_res;
                c = sh_c;
            end
            default: listed = 1'b0;
        endcase
    end

    // Unlisted opcodes feed the current register contents back, so a capture is a no-op.
    always_comb begin
        res_next   = res_q;
        flags_next = flags_q;
        if (listed) begin
            res_next           = r;
            flags_next[FLAG_C] = c;
            flags_next[FLAG_Z] = (r == '0);
            flags_next[FLAG_N] = r[DATA_W-1];
            flags_next[FLAG_V] = v;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (out_en) begin
            res_q   <= res_next;
            flags_q <= flags_next;
        end
    end

    assign out   = out_en ? res_q : 'z;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table, directed and randomized checks of alu against a behavioural model
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        ar_flag;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        out_en;
    wire  [15:0] out;
    logic [3:0]  flags;

    wire out_is_z = (out === 16'hzzzz);

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_res   = '0;
    logic [3:0]  exp_flags = '0;

    typedef struct {
        logic [3:0]  op;
        logic        ar;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .ar_flag (ar_flag),
        .src1    (src1),
        .src2    (src2),
        .out_en  (out_en),
        .out     (out),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    // Returns {listed, result[15:0], flags{C,Z,N,V}} from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [3:0] op, input logic ar,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        logic        cy, ov, ok;
        int          n, s, sa, sb;
        longint      wide;
        res = 16'h0; cy = 1'b0; ov = 1'b0; ok = 1'b1;
        n  = int'(b % 16);
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'b0011: begin
                wide = longint'(a) + longint'(b);
                res  = 16'(wide);
                cy   = wide > 65535;
                s    = sa + sb;
                ov   = (s > 32767) || (s < -32768);
            end
            4'b0100: begin
                res = 16'(a - b);
                cy  = a < b;
                s   = sa - sb;
                ov  = (s > 32767) || (s < -32768);
            end
            4'b0101: begin
                wide = longint'(a) * longint'(b);
                res  = 16'(wide);
                cy   = wide > 65535;
                ov   = cy;
            end
            4'b0110: begin
                if (b == 0) begin
                    res = 16'hFFFF;
                    ov  = 1'b1;
                end else begin
                    res = a / b;
                end
            end
            4'b0111: res = a & b;
            4'b1000: res = a | b;
            4'b1001: res = a ^ b;
            4'b1010: begin
                if (ar) begin
                    res = a;
                    for (int i = 0; i < n; i++) res = {res[14:0], res[15]};
                    cy = (n != 0) ? res[0] : 1'b0;
                end else begin
                    res = a << n;
                    cy  = (n != 0) ? a[16 - n] : 1'b0;
                end
            end
            4'b1011: begin
                if (ar) begin
                    res = a;
                    for (int i = 0; i < n; i++) res = {res[0], res[15:1]};
                    cy = (n != 0) ? res[15] : 1'b0;
                end else begin
                    res = a >> n;
                    cy  = (n != 0) ? a[n - 1] : 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        return {ok, res, cy, (res == 16'h0), res[15], ov};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        if (out_en) check({name, "_out"}, {16'h0, out}, {16'h0, exp_res});
        else        check({name, "_hiz"}, {31'h0, out_is_z}, 32'd1);
        check({name, "_flags"}, {28'h0, flags}, {28'h0, exp_flags});
    endtask

    // One rising edge with the model updated from the inputs seen at that edge.
    task automatic tick();
        logic [20:0] m;
        @(posedge clk);
        m = model(opcode, ar_flag, src1, src2);
        if (!rst) begin
            exp_res   = '0;
            exp_flags = '0;
        end else if (out_en && m[20]) begin
            exp_res   = m[19:4];
            exp_flags = m[3:0];
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] op, input logic ar, input logic [15:0] a,
                          input logic [15:0] b);
        opcode  = op;
        ar_flag = ar;
        src1    = a;
        src2    = b;
    endtask

    initial begin
        vecs.push_back(vec_t'{OP_ADD, 1'b0, 16'd10,    16'd5,     16'd15,    4'b0000});
        vecs.push_back(vec_t'{OP_SUB, 1'b0, 16'd10,    16'd5,     16'd5,     4'b0000});
        vecs.push_back(vec_t'{OP_MUL, 1'b0, 16'd10,    16'd5,     16'd50,    4'b0000});
        vecs.push_back(vec_t'{OP_DIV, 1'b0, 16'd10,    16'd5,     16'd2,     4'b0000});
        vecs.push_back(vec_t'{OP_AND, 1'b0, 16'd10,    16'd5,     16'd0,     4'b0100});
        vecs.push_back(vec_t'{OP_OR,  1'b0, 16'd10,    16'd5,     16'd15,    4'b0000});
        vecs.push_back(vec_t'{OP_XOR, 1'b0, 16'd10,    16'd5,     16'd15,    4'b0000});
        vecs.push_back(vec_t'{OP_SHL, 1'b0, 16'd10,    16'd5,     16'd320,   4'b0000});
        vecs.push_back(vec_t'{OP_SHR, 1'b0, 16'd10,    16'd5,     16'd0,     4'b0100});
        vecs.push_back(vec_t'{OP_SHL, 1'b1, 16'd10,    16'd5,     16'd320,   4'b0000});
        vecs.push_back(vec_t'{OP_SHR, 1'b1, 16'd10,    16'd5,     16'h5000,  4'b0000});
        vecs.push_back(vec_t'{OP_ADD, 1'b0, 16'hFFFF,  16'd1,     16'h0000,  4'b1100});
        vecs.push_back(vec_t'{OP_ADD, 1'b0, 16'h7FFF,  16'd1,     16'h8000,  4'b0011});
        vecs.push_back(vec_t'{OP_SUB, 1'b0, 16'h0000,  16'd1,     16'hFFFF,  4'b1010});
        vecs.push_back(vec_t'{OP_SUB, 1'b0, 16'h8000,  16'd1,     16'h7FFF,  4'b0001});
        vecs.push_back(vec_t'{OP_DIV, 1'b0, 16'd7,     16'd0,     16'hFFFF,  4'b0011});
        vecs.push_back(vec_t'{OP_MUL, 1'b0, 16'h0100,  16'h0100,  16'h0000,  4'b1101});
        vecs.push_back(vec_t'{OP_SHL, 1'b0, 16'h8001,  16'h0000,  16'h8001,  4'b0010});
        vecs.push_back(vec_t'{OP_SHR, 1'b1, 16'h8001,  16'h0010,  16'h8001,  4'b0010});
        vecs.push_back(vec_t'{OP_SHL, 1'b0, 16'h8000,  16'd1,     16'h0000,  4'b1100});
        vecs.push_back(vec_t'{OP_SHL, 1'b1, 16'h8000,  16'd1,     16'h0001,  4'b1000});
        vecs.push_back(vec_t'{OP_SHR, 1'b1, 16'h0001,  16'd1,     16'h8000,  4'b1010});

        rst    = 1'b0;
        out_en = 1'b0;
        set_in(OP_ADD, 1'b0, 16'd10, 16'd5);
        tick();
        tick();
        check_state("reset");
        out_en = 1'b1;
        #1;
        check("reset_out_zero", {16'h0, out}, 32'h0);
        out_en = 1'b0;
        rst    = 1'b1;
        tick();
        check_state("release_no_en");
        out_en = 1'b1;
        tick();
        check("first_capture", {16'h0, out}, 32'd15);
        check_state("first_capture_model");

        foreach (vecs[i]) begin
            set_in(vecs[i].op, vecs[i].ar, vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("vec%0d_out", i), {16'h0, out}, {16'h0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {28'h0, flags}, {28'h0, vecs[i].fl});
        end

        set_in(OP_ADD, 1'b0, 16'd10, 16'd5);
        tick();
        out_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(4'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 16'($urandom));
            tick();
            check_state($sformatf("hold%0d", i));
            check($sformatf("hold%0d_flags_const", i), {28'h0, flags}, 32'h0);
        end
        out_en = 1'b1;
        #1;
        check("hold_reappear", {16'h0, out}, 32'd15);

        @(negedge clk);
        set_in(OP_SUB, 1'b0, 16'h0000, 16'd1);
        tick();
        set_in(4'b1111, 1'b0, 16'h1234, 16'h5678);
        tick();
        check("unlisted_out", {16'h0, out}, 32'h0000FFFF);
        check("unlisted_flags", {28'h0, flags}, 32'b1010);

        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out", {16'h0, out}, 32'h0);
        check("async_rst_flags", {28'h0, flags}, 32'h0);
        exp_res   = '0;
        exp_flags = '0;
        set_in(OP_ADD, 1'b0, 16'd3, 16'd4);
        tick();
        check_state("rst_held");
        rst = 1'b1;
        tick();
        check("post_rst_capture", {16'h0, out}, 32'd7);

        for (int i = 0; i < 400; i++) begin
            set_in(4'($urandom_range(0, 15)), 1'($urandom), 16'($urandom),
                   ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
            out_en = ($urandom_range(0, 3) != 0);
            tick();
            check_state($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
